// File: rtl/cfu_if.sv
// CFU request/response port bundle: the CPU side is the master and the compute unit is the slave.
interface cfu_if #(
  parameter int REQ_ID_W   = 4,
  parameter int CFU_ID_W   = 4,
  parameter int STATE_ID_W = 3,
  parameter int FUNC_ID_W  = 3,
  parameter int INSN_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STATUS_W   = 2
) ();
  logic                  req_en;
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_cfu_csr;
  logic [REQ_ID_W-1:0]   req_id;
  logic [CFU_ID_W-1:0]   req_cfu;
  logic [STATE_ID_W-1:0] req_state;
  logic [FUNC_ID_W-1:0]  req_func;
  logic [INSN_W-1:0]     req_insn;
  logic [DATA_W-1:0]     req_data0;
  logic [DATA_W-1:0]     req_data1;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [REQ_ID_W-1:0]   resp_id;
  logic [STATUS_W-1:0]   resp_status;
  logic [DATA_W-1:0]     resp_data;

  // Both channels transfer on a rising edge where valid && ready; the sender holds its payload
  // until then, and the unit's ready never depends combinationally on the sender's valid.
  modport master (
    output req_en, req_valid, req_cfu_csr, req_id, req_cfu, req_state, req_func,
           req_insn, req_data0, req_data1, resp_ready,
    input  req_ready, resp_valid, resp_id, resp_status, resp_data
  );

  modport slave (
    input  req_en, req_valid, req_cfu_csr, req_id, req_cfu, req_state, req_func,
           req_insn, req_data0, req_data1, resp_ready,
    output req_ready, resp_valid, resp_id, resp_status, resp_data
  );
endinterface

// File: rtl/cfu_mac_unit.sv
// Accumulating MAC custom function unit: two-stage pipeline (operands/product, accumulator RMW)
// into an in-order response FIFO whose depth also bounds the number of requests in flight.
module cfu_mac_unit #(
  parameter int CFU_ID     = 0,
  parameter int NUM_ACC    = 4,
  parameter int RESP_DEPTH = 4,
  parameter int REQ_ID_W   = 4,
  parameter int CFU_ID_W   = 4,
  parameter int STATE_ID_W = 3,
  parameter int FUNC_ID_W  = 3,
  parameter int DATA_W     = 32,
  parameter int STATUS_W   = 2
) (
  input logic   clk,
  input logic   rst,
  cfu_if.slave  bus
);
  localparam int IDX_W = (NUM_ACC > 1) ? $clog2(NUM_ACC) : 1;
  localparam int PTR_W = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
  localparam int CNT_W = $clog2(RESP_DEPTH + 1);
  localparam int OCC_W = CNT_W + 1;

  localparam logic [FUNC_ID_W-1:0] F_ADD   = FUNC_ID_W'(0);
  localparam logic [FUNC_ID_W-1:0] F_MAC   = FUNC_ID_W'(1);
  localparam logic [FUNC_ID_W-1:0] F_RDACC = FUNC_ID_W'(2);
  localparam logic [FUNC_ID_W-1:0] F_WRACC = FUNC_ID_W'(3);
  localparam logic [FUNC_ID_W-1:0] F_MULHU = FUNC_ID_W'(4);
  localparam logic [STATUS_W-1:0]  ST_OK   = STATUS_W'(0);
  localparam logic [STATUS_W-1:0]  ST_ERR  = STATUS_W'(1);

  typedef struct packed {
    logic [REQ_ID_W-1:0] id;
    logic [STATUS_W-1:0] status;
    logic [DATA_W-1:0]   data;
  } resp_t;

  logic                  s1_valid_q, s2_valid_q;
  logic [REQ_ID_W-1:0]   s1_id_q, s2_id_q;
  logic [FUNC_ID_W-1:0]  s1_func_q, s2_func_q;
  logic                  s1_err_q, s2_err_q;
  logic [IDX_W-1:0]      s1_idx_q, s2_idx_q;
  logic [DATA_W-1:0]     s1_a_q, s1_b_q, s2_a_q, s2_b_q;
  logic [2*DATA_W-1:0]   s2_prod_q;
  logic [DATA_W-1:0]     acc_q [NUM_ACC];
  resp_t                 mem_q [RESP_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [OCC_W-1:0]      occ;
  logic                  accept, req_err, push, pop;
  logic                  acc_wr;
  logic [DATA_W-1:0]     acc_cur, acc_wdata;
  resp_t                 push_entry, head;
  logic                  unused_insn;

  assign unused_insn = ^bus.req_insn;

  // Credit covers both pipeline stages, so every request that enters always finds a FIFO slot.
  assign occ           = OCC_W'(s1_valid_q) + OCC_W'(s2_valid_q) + OCC_W'(count_q);
  assign bus.req_ready = rst && bus.req_en && (occ < OCC_W'(RESP_DEPTH));
  assign accept        = bus.req_valid && bus.req_ready;

  assign req_err = (bus.req_cfu != CFU_ID_W'(CFU_ID)) || bus.req_cfu_csr ||
                   ({1'b0, bus.req_state} >= (STATE_ID_W + 1)'(NUM_ACC)) ||
                   (bus.req_func > F_MULHU);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid_q <= 1'b0;  s2_valid_q <= 1'b0;
      s1_id_q    <= '0;    s2_id_q    <= '0;
      s1_func_q  <= '0;    s2_func_q  <= '0;
      s1_err_q   <= 1'b0;  s2_err_q   <= 1'b0;
      s1_idx_q   <= '0;    s2_idx_q   <= '0;
      s1_a_q     <= '0;    s1_b_q     <= '0;
      s2_a_q     <= '0;    s2_b_q     <= '0;
      s2_prod_q  <= '0;
    end else begin
      s1_valid_q <= accept;
      if (accept) begin
        s1_id_q   <= bus.req_id;
        s1_func_q <= bus.req_func;
        s1_err_q  <= req_err;
        s1_idx_q  <= bus.req_state[IDX_W-1:0];
        s1_a_q    <= bus.req_data0;
        s1_b_q    <= bus.req_data1;
      end
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_id_q   <= s1_id_q;
        s2_func_q <= s1_func_q;
        s2_err_q  <= s1_err_q;
        s2_idx_q  <= s1_idx_q;
        s2_a_q    <= s1_a_q;
        s2_b_q    <= s1_b_q;
        s2_prod_q <= {{DATA_W{1'b0}}, s1_a_q} * {{DATA_W{1'b0}}, s1_b_q};
      end
    end
  end

  // All accumulator reads and writes happen here, so consecutive ops on one index need no bypass.
  always_comb begin
    acc_cur           = acc_q[s2_idx_q];
    acc_wr            = 1'b0;
    acc_wdata         = '0;
    push_entry.id     = s2_id_q;
    push_entry.status = ST_OK;
    push_entry.data   = '0;
    if (s2_err_q) begin
      push_entry.status = ST_ERR;
    end else begin
      case (s2_func_q)
        F_ADD:   push_entry.data = s2_a_q + s2_b_q;
        F_MAC: begin
          acc_wr          = 1'b1;
          acc_wdata       = acc_cur + s2_prod_q[DATA_W-1:0];
          push_entry.data = acc_wdata;
        end
        F_RDACC: push_entry.data = acc_cur;
        F_WRACC: begin
          acc_wr          = 1'b1;
          acc_wdata       = s2_a_q;
          push_entry.data = acc_cur;
        end
        F_MULHU: push_entry.data = s2_prod_q[2*DATA_W-1:DATA_W];
        default: push_entry.status = ST_ERR;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_ACC; i++) acc_q[i] <= '0;
    end else if (s2_valid_q && acc_wr) begin
      acc_q[s2_idx_q] <= acc_wdata;
    end
  end

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(RESP_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign push = s2_valid_q;
  assign pop  = bus.resp_valid && bus.resp_ready;

  always_comb begin
    count_d = count_q;
    if (push && !pop)      count_d = count_q + CNT_W'(1);
    else if (!push && pop) count_d = count_q - CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_entry;
  end

  assign head            = mem_q[rd_ptr_q];
  assign bus.resp_valid  = (count_q != '0);
  assign bus.resp_id     = bus.resp_valid ? head.id     : '0;
  assign bus.resp_status = bus.resp_valid ? head.status : '0;
  assign bus.resp_data   = bus.resp_valid ? head.data   : '0;

  a_no_overflow:  assert property (@(posedge clk) disable iff (!rst)
                    !(push && !pop && (count_q == CNT_W'(RESP_DEPTH))));
  a_no_underflow: assert property (@(posedge clk) disable iff (!rst)
                    !(pop && (count_q == '0)));
  a_credit:       assert property (@(posedge clk) disable iff (!rst)
                    occ <= OCC_W'(RESP_DEPTH));
endmodule

// File: tb/tb_cfu_mac_unit.sv
// Bench for cfu_mac_unit: directed and random requests, expected responses from an arithmetic
// reference model queued at acceptance and compared by an independent response monitor.
module tb_cfu_mac_unit;
  localparam int DEPTH = 4;
  localparam int EW    = 4 + 2 + 32;

  typedef struct packed {
    logic [3:0]  id;
    logic [3:0]  cfu;
    logic        csr;
    logic [2:0]  state;
    logic [2:0]  func;
    logic [31:0] a;
    logic [31:0] b;
  } req_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;
  logic [EW-1:0] exp_q[$];
  logic [31:0]   m_acc[4];
  logic          held = 1'b0;
  logic [EW-1:0] held_v;

  cfu_if #(.REQ_ID_W(4), .CFU_ID_W(4), .STATE_ID_W(3), .FUNC_ID_W(3),
           .INSN_W(32), .DATA_W(32), .STATUS_W(2)) bus ();

  cfu_mac_unit #(.CFU_ID(0), .NUM_ACC(4), .RESP_DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic void chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endfunction

  // Reference model: the arithmetic each function defines, applied in acceptance order.
  task automatic push_exp(input req_t r);
    logic [31:0] d;
    logic [1:0]  st;
    logic [63:0] full;
    d  = '0;
    st = 2'd0;
    if (r.cfu != 4'd0 || r.csr || r.state >= 3'd4 || r.func > 3'd4) begin
      st = 2'd1;
    end else begin
      case (r.func)
        3'd0: d = r.a + r.b;
        3'd1: begin m_acc[r.state[1:0]] = m_acc[r.state[1:0]] + r.a * r.b; d = m_acc[r.state[1:0]]; end
        3'd2: d = m_acc[r.state[1:0]];
        3'd3: begin d = m_acc[r.state[1:0]]; m_acc[r.state[1:0]] = r.a; end
        3'd4: begin full = {32'd0, r.a} * {32'd0, r.b}; d = full[63:32]; end
        default: d = '0;
      endcase
    end
    exp_q.push_back({r.id, st, d});
  endtask

  function automatic req_t mk(input logic [3:0] id, input logic [3:0] cfu, input logic [2:0] state,
                              input logic [2:0] func, input logic [31:0] a, input logic [31:0] b);
    req_t r;
    r.id = id; r.cfu = cfu; r.csr = 1'b0; r.state = state; r.func = func; r.a = a; r.b = b;
    return r;
  endfunction

  function automatic req_t rand_req(input logic [3:0] id);
    req_t r;
    r.id    = id;
    r.cfu   = ($urandom_range(0, 9) == 0) ? 4'd1 : 4'd0;
    r.csr   = ($urandom_range(0, 15) == 0);
    r.state = 3'($urandom_range(0, 4));
    r.func  = 3'($urandom_range(0, 7));
    r.a     = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
    r.b     = $urandom;
    return r;
  endfunction

  task automatic drive(input req_t r);
    bus.req_id      = r.id;
    bus.req_cfu     = r.cfu;
    bus.req_cfu_csr = r.csr;
    bus.req_state   = r.state;
    bus.req_func    = r.func;
    bus.req_data0   = r.a;
    bus.req_data1   = r.b;
    bus.req_insn    = $urandom;
  endtask

  // Called just after a rising edge; returns just after the edge that accepted the request.
  task automatic send(input req_t r, output int stalls);
    bit done;
    done   = 1'b0;
    stalls = 0;
    drive(r);
    bus.req_valid = 1'b1;
    while (!done) begin
      @(negedge clk);
      if (bus.req_ready) begin
        done = 1'b1;
        push_exp(r);
      end
      @(posedge clk); #1;
      if (!done) begin
        stalls++;
        if (stalls > 50) begin
          chk("send_timeout", 64'(stalls), 64'd0);
          done = 1'b1;
        end
      end
    end
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || bus.resp_valid) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk(name, 64'(exp_q.size()), 64'd0);
  endtask

  // Response monitor: pops and compares on each transfer, and checks the head stays put while stalled.
  always @(negedge clk) begin
    logic [EW-1:0] cur;
    logic [EW-1:0] e;
    cur = {bus.resp_id, bus.resp_status, bus.resp_data};
    if (!rst) begin
      held = 1'b0;
    end else begin
      if (held && bus.resp_valid) chk("resp_hold", 64'(cur), 64'(held_v));
      held   = bus.resp_valid && !bus.resp_ready;
      held_v = cur;
      if (bus.resp_valid && bus.resp_ready) begin
        if (exp_q.size() == 0) begin
          chk("resp_unexpected", 64'(cur), 64'd0);
        end else begin
          e = exp_q.pop_front();
          chk("resp", 64'(cur), 64'(e));
        end
      end
    end
  end

  initial begin
    int   st, tot, n;
    req_t r;
    for (int i = 0; i < 4; i++) m_acc[i] = '0;
    bus.req_en = 1'b1; bus.req_valid = 1'b0; bus.resp_ready = 1'b1;
    drive(mk(4'd0, 4'd0, 3'd0, 3'd0, 32'd0, 32'd0));

    #12;
    chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
    chk("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
    chk("rst_resp_fields", 64'({bus.resp_id, bus.resp_status, bus.resp_data}), 64'd0);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;

    // Single ADD with wraparound and exact latency.
    send(mk(4'd5, 4'd0, 3'd0, 3'd0, 32'hFFFF_FFFF, 32'd2), st);
    bus.req_valid = 1'b0;
    @(negedge clk); chk("lat_s1", 64'(bus.resp_valid), 64'd0);
    @(negedge clk); chk("lat_s2", 64'(bus.resp_valid), 64'd0);
    @(negedge clk); chk("lat_out", 64'(bus.resp_valid), 64'd1);
    chk("add_data", 64'({bus.resp_id, bus.resp_status, bus.resp_data}), {26'd0, 4'd5, 2'd0, 32'd1});
    @(posedge clk); #1;
    wait_drain("drain_add");

    // Back-to-back accumulator chain on index 1.
    send(mk(4'd1, 4'd0, 3'd1, 3'd3, 32'd10, 32'd0), st);
    send(mk(4'd2, 4'd0, 3'd1, 3'd1, 32'd3, 32'd4), st);
    send(mk(4'd3, 4'd0, 3'd1, 3'd1, 32'd5, 32'd6), st);
    send(mk(4'd4, 4'd0, 3'd1, 3'd2, 32'd0, 32'd0), st);
    send(mk(4'd5, 4'd0, 3'd0, 3'd2, 32'd0, 32'd0), st);
    bus.req_valid = 1'b0;
    wait_drain("drain_mac");
    chk("model_acc1", 64'(m_acc[1]), 64'd52);

    // MULHU and the error cases, then confirm no accumulator moved.
    send(mk(4'd6, 4'd0, 3'd0, 3'd4, 32'h8000_0000, 32'd4), st);
    send(mk(4'd7, 4'd0, 3'd0, 3'd7, 32'd1, 32'd1), st);
    send(mk(4'd8, 4'd1, 3'd0, 3'd0, 32'd1, 32'd1), st);
    send(mk(4'd9, 4'd0, 3'd4, 3'd1, 32'd7, 32'd7), st);
    r = mk(4'd10, 4'd0, 3'd0, 3'd3, 32'd99, 32'd0);
    r.csr = 1'b1;
    send(r, st);
    for (int i = 0; i < 4; i++) send(mk(4'(11 + i), 4'd0, 3'(i), 3'd2, 32'd0, 32'd0), st);
    bus.req_valid = 1'b0;
    wait_drain("drain_err");

    // Backpressure: exactly DEPTH accepts, then the freed slot reopens one cycle after the first pop.
    bus.resp_ready = 1'b0;
    n = 0;
    r = rand_req(4'd0);
    drive(r);
    bus.req_valid = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (bus.req_ready) begin
        push_exp(r);
        n++;
        r = rand_req(4'(n));
      end
      @(posedge clk); #1;
      drive(r);
    end
    chk("bp_accepts", 64'(n), 64'(DEPTH));
    chk("bp_ready_low", 64'(bus.req_ready), 64'd0);
    bus.resp_ready = 1'b1;
    @(negedge clk);
    chk("bp_ready_pop_cycle", 64'(bus.req_ready), 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_ready_after_pop", 64'(bus.req_ready), 64'd1);
    if (bus.req_ready) push_exp(r);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    wait_drain("drain_bp");

    // Enable dropped mid-stream: no new accepts, in-flight work still drains.
    send(rand_req(4'd1), st);
    send(rand_req(4'd2), st);
    bus.req_en = 1'b0;
    n = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (bus.req_ready) n++;
      @(posedge clk); #1;
    end
    chk("en_off_accepts", 64'(n), 64'd0);
    bus.req_valid = 1'b0;
    bus.req_en    = 1'b1;
    wait_drain("drain_en");

    // Throughput: random back-to-back stream, one accept per cycle.
    tot = 0;
    for (int i = 0; i < 100; i++) begin
      send(rand_req(4'(i)), st);
      tot += st;
    end
    bus.req_valid = 1'b0;
    chk("tp_stalls", 64'(tot), 64'd0);
    wait_drain("drain_tp");

    // Reset with work in flight.
    send(mk(4'd1, 4'd0, 3'd2, 3'd3, 32'd77, 32'd0), st);
    bus.resp_ready = 1'b0;
    send(mk(4'd2, 4'd0, 3'd3, 3'd1, 32'd5, 32'd5), st);
    send(mk(4'd3, 4'd0, 3'd0, 3'd3, 32'd9, 32'd0), st);
    #2;
    rst = 1'b0;
    #1;
    chk("rst_mid_resp_valid", 64'(bus.resp_valid), 64'd0);
    chk("rst_mid_req_ready", 64'(bus.req_ready), 64'd0);
    exp_q.delete();
    for (int i = 0; i < 4; i++) m_acc[i] = '0;
    bus.req_valid  = 1'b0;
    bus.resp_ready = 1'b1;
    @(negedge clk); rst = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("rst_no_emit", 64'(bus.resp_valid), 64'd0);
    end
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) send(mk(4'(i), 4'd0, 3'(i), 3'd2, 32'd0, 32'd0), st);
    bus.req_valid = 1'b0;
    wait_drain("drain_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
